// File: rtl/nanci_pkg.sv
// Shared types and helpers for the Nanci mesh edge blocks.
package nanci_pkg;

    // Address 0 means "no word" to a PE, so the null word is all zeros.
    localparam int unsigned NULL_WORD = 0;

    function automatic int unsigned word_w(input int unsigned a, input int unsigned d);
        return a + d;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/nanci_fifo.sv
// Parameterised synchronous FIFO with async active-low reset and occupancy outputs.
module nanci_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/nanci_edge_tx.sv
// Mesh edge transmitter: buffers {addr, data} words and plays frames of them onto
// one PE neighbour link, holding each word for the PE sort step.
module nanci_edge_tx
    import nanci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FRAME_LEN   = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word,
    input  logic                             i_start,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_link,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_underrun
);

    localparam int unsigned W  = word_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned FW = $clog2(FRAME_LEN+1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES+1);

    state_e          state_q, state_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [W-1:0]    link_q, link_d;
    logic            underrun_q, underrun_d;

    logic            push, pop;
    logic [W-1:0]    fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;

    assign o_ready = (fifo_count != CW'(DEPTH));
    assign push    = i_valid && !fifo_full;

    nanci_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (i_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        link_d      = link_q;
        underrun_d  = underrun_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                link_d = W'(NULL_WORD);
                if (i_start) begin
                    state_d     = StLoad;
                    frame_cnt_d = '0;
                    underrun_d  = 1'b0;
                end
            end
            StLoad: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    link_d     = fifo_rdata;
                    hold_cnt_d = '0;
                    state_d    = StHold;
                end else begin
                    link_d     = W'(NULL_WORD);
                    underrun_d = 1'b1;
                end
            end
            StHold: begin
                // Counters are tested before incrementing so they never wrap.
                if (hold_cnt_q == HW'(HOLD_CYCLES-1)) begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                    link_d      = W'(NULL_WORD);
                    state_d     = (frame_cnt_q == FW'(FRAME_LEN-1)) ? StDone : StLoad;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            StDone: begin
                link_d  = W'(NULL_WORD);
                state_d = StIdle;
            end
            default: begin
                link_d  = W'(NULL_WORD);
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            link_q      <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            link_q      <= link_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_link     = link_q;
    assign o_busy     = (state_q == StLoad) || (state_q == StHold);
    assign o_done     = (state_q == StDone);
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_nanci_edge_tx.sv
// Bench for nanci_edge_tx: two instances (hold 1 and hold 3) share stimulus and are
// checked every cycle against a queue-based frame model plus literal expectations.
module tb_nanci_edge_tx;

    localparam int unsigned FL  = 2;
    localparam int unsigned DEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_start = 1'b0;
    logic [5:0] i_word = '0;

    logic [5:0] link_o  [2];
    logic       ready_o [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       und_o   [2];

    always #5 clk = ~clk;

    nanci_edge_tx #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(4), .FRAME_LEN(2), .HOLD_CYCLES(1)
    ) dut_h1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_o[0]), .i_word(i_word),
        .i_start(i_start), .o_link(link_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
        .o_underrun(und_o[0])
    );

    nanci_edge_tx #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(4), .FRAME_LEN(2), .HOLD_CYCLES(3)
    ) dut_h3 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_o[1]), .i_word(i_word),
        .i_start(i_start), .o_link(link_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
        .o_underrun(und_o[1])
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
    endtask

    // Behavioural model: a word queue plus frame progress per instance.
    logic [5:0] fq [2][8];
    int         fn   [2] = '{0, 0};
    bit         act  [2] = '{0, 0};
    bit         onl  [2] = '{0, 0};
    bit         dpl  [2] = '{0, 0};
    bit         und  [2] = '{0, 0};
    logic [5:0] mlink[2] = '{6'd0, 6'd0};
    int         held [2] = '{0, 0};
    int         sent [2] = '{0, 0};
    bit         m_push;

    function automatic int hold_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                fn[d] = 0; act[d] = 0; onl[d] = 0; dpl[d] = 0; und[d] = 0; mlink[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_push = i_valid && (fn[d] < DEP);
                if (dpl[d]) begin
                    dpl[d] = 0;
                end else if (!act[d]) begin
                    if (i_start) begin act[d] = 1; sent[d] = 0; und[d] = 0; end
                end else if (onl[d]) begin
                    held[d]++;
                    if (held[d] == hold_of(d)) begin
                        onl[d] = 0; mlink[d] = '0; sent[d]++;
                        if (sent[d] == FL) begin act[d] = 0; dpl[d] = 1; end
                    end
                end else if (fn[d] > 0) begin
                    mlink[d] = fq[d][0];
                    for (int i = 0; i < 7; i++) fq[d][i] = fq[d][i+1];
                    fn[d]--; onl[d] = 1; held[d] = 0;
                end else begin
                    und[d] = 1;
                end
                if (m_push) begin fq[d][fn[d]] = i_word; fn[d]++; end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("link",  d, link_o[d],  mlink[d]);
            chk("busy",  d, busy_o[d],  act[d]);
            chk("done",  d, done_o[d],  dpl[d]);
            chk("under", d, und_o[d],   und[d]);
            chk("ready", d, ready_o[d], fn[d] < DEP);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [5:0] w);
        i_valid = 1'b1; i_word = w; tick(); i_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o[0] || busy_o[1] || done_o[0] || done_o[1]) && n < 100) begin
            tick(); n++;
        end
        if (n >= 100) chk("idle_timeout", 0, busy_o[0] || busy_o[1], 0);
    endtask

    initial begin
        logic [5:0] t2 [6];
        logic [5:0] t6 [10];
        logic [5:0] bp [5];
        int nz, nd, n;
        t2 = '{6'd0, 6'd0, 6'b011000, 6'd0, 6'b001101, 6'd0};
        t6 = '{6'd0, 6'd0, 6'd33, 6'd33, 6'd33, 6'd0, 6'd34, 6'd34, 6'd34, 6'd0};
        bp = '{6'd41, 6'd0, 6'd7, 6'd62, 6'd19};

        // Reset held with valid high: nothing may be accepted.
        rst = 1'b0; i_valid = 1'b1; i_word = 6'h3f;
        repeat (20) tick();
        chk("rst_link", 0, link_o[0], 0);
        chk("rst_ready", 0, ready_o[0], 1);
        chk("rst_busy", 0, busy_o[0], 0);
        i_valid = 1'b0; rst = 1'b1;
        tick();

        // Single frame: null, null, word0, null, word1, null with done on the last.
        push_word(6'b011000);
        push_word(6'b001101);
        i_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t2_link", 0, link_o[0], t2[i]);
            chk("t2_done", 0, done_o[0], i == 5);
            tick();
            if (i == 0) i_start = 1'b0;
        end
        wait_idle();
        chk("t2_empty", 0, ready_o[0], 1);

        // Underrun, then a late word appears two cycles after its push.
        pulse_start();
        tick();
        chk("t4_busy", 0, busy_o[0], 1);
        chk("t4_under", 0, und_o[0], 1);
        chk("t4_link", 0, link_o[0], 0);
        i_valid = 1'b1; i_word = 6'b010111; tick(); i_valid = 1'b0;
        chk("t4_link1", 0, link_o[0], 0);
        tick();
        chk("t4_link2", 0, link_o[0], 6'b010111);
        push_word(6'd5);
        wait_idle();
        chk("t4_sticky", 0, und_o[0], 1);
        pulse_start();
        chk("t4_clear", 0, und_o[0], 0);
        push_word(6'd12);
        push_word(6'd44);
        wait_idle();

        // Backpressure: four fill the FIFO, the fifth waits for a pop.
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin i_word = bp[k]; tick(); end
        i_word = bp[4];
        chk("t3_full", 0, ready_o[0], 0);
        tick();
        chk("t3_full2", 0, ready_o[0], 0);
        i_start = 1'b1; tick(); i_start = 1'b0;
        n = 0;
        while (!ready_o[0] && n < 20) begin tick(); n++; end
        if (n >= 20) chk("t3_ready_timeout", 0, ready_o[0], 1);
        tick();
        i_valid = 1'b0;
        wait_idle();
        pulse_start(); wait_idle();
        pulse_start(); push_word(6'd27); wait_idle();

        // Reset during the hold of word 1.
        push_word(6'd9);
        push_word(6'd50);
        pulse_start();
        n = 0;
        while (link_o[0] == 6'd0 && n < 10) begin tick(); n++; end
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_link", d, link_o[d], 0);
            chk("t5_busy", d, busy_o[d], 0);
            chk("t5_done", d, done_o[d], 0);
            chk("t5_ready", d, ready_o[d], 1);
        end
        tick();
        rst = 1'b1;
        tick();

        // A second start mid-frame is ignored: exactly two words, one done.
        push_word(6'd9);
        push_word(6'd50);
        pulse_start();
        nz = 0; nd = 0;
        for (int c = 0; c < 60; c++) begin
            if (link_o[0] != 6'd0) nz++;
            if (done_o[0]) nd++;
            if (c == 1) i_start = 1'b1;
            if (c == 2) i_start = 1'b0;
            tick();
            if (c > 2 && !(busy_o[0] || busy_o[1] || done_o[0] || done_o[1])) break;
        end
        chk("t5_words", 0, nz, 2);
        chk("t5_dones", 0, nd, 1);

        // Hold of three cycles with a single null gap between words.
        push_word(6'b100001);
        push_word(6'b100010);
        i_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t6_link", 1, link_o[1], t6[i]);
            tick();
            if (i == 0) i_start = 1'b0;
        end
        chk("t6_done", 1, done_o[1], 0);
        wait_idle();

        // Random traffic with an occasional asynchronous reset.
        for (int k = 0; k < 600; k++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_word  = 6'($urandom);
            i_start = ($urandom_range(0, 7) == 0);
            if (k % 200 == 199) begin
                #2 rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
